// File: rtl/pixel_rx_ctrl.sv
// Serial pixel receiver controller: synchronizes the line, times the bits of each frame,
// strobes an external LSB-first shift register and counts pixels per image.
// Optional even-parity checking is compiled in by defining PIXEL_RX_PARITY_EN.
module pixel_rx_ctrl #(
    parameter int NUM_BITS         = 8,
    parameter int CLKS_PER_BIT     = 10,
    parameter int PIXELS_PER_IMAGE = 784
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic                                serial_in,
    output logic                                serial_sync,
    output logic                                shift_enable,
    output logic                                load_pixel,
    output logic                                framing_error,
    output logic                                parity_error,
    output logic [$clog2(PIXELS_PER_IMAGE)-1:0] pixel_count,
    output logic                                image_done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(NUM_BITS + 1);
    localparam int CW = $clog2(PIXELS_PER_IMAGE);

    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NUM_BITS - 1);
    localparam logic [CW-1:0] PIX_LAST  = CW'(PIXELS_PER_IMAGE - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_LOAD   = 3'd5;

    logic          sync1_q, sync2_q, sync_prev_q;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic          ferr_q, ferr_d;
    logic          perr_q, perr_d;
    logic          start_edge, half_tick, bit_tick, parity_bad;

`ifdef PIXEL_RX_PARITY_EN
    logic          par_acc_q, par_acc_d;
`endif

    assign start_edge = sync_prev_q & ~sync2_q;
    assign half_tick  = (timer_q == HALF_LAST);
    assign bit_tick   = (timer_q == BIT_LAST);

`ifdef PIXEL_RX_PARITY_EN
    // Even parity: XOR over data bits and parity bit must come out zero.
    assign parity_bad = par_acc_q;
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        bit_cnt_d = bit_cnt_q;
        pix_cnt_d = pix_cnt_q;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
`ifdef PIXEL_RX_PARITY_EN
        par_acc_d = par_acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                timer_d   = '0;
                bit_cnt_d = '0;
`ifdef PIXEL_RX_PARITY_EN
                par_acc_d = 1'b0;
`endif
                if (start_edge) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (half_tick) begin
                    timer_d = '0;
                    state_d = serial_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    timer_d   = '0;
                    bit_cnt_d = bit_cnt_q + BW'(1);
`ifdef PIXEL_RX_PARITY_EN
                    par_acc_d = par_acc_q ^ serial_sync;
`endif
                    if (bit_cnt_q == DATA_LAST) begin
`ifdef PIXEL_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
            ST_PARITY: begin
`ifdef PIXEL_RX_PARITY_EN
                if (bit_tick) begin
                    timer_d   = '0;
                    par_acc_d = par_acc_q ^ serial_sync;
                    state_d   = ST_STOP;
                end
`else
                timer_d = '0;
                state_d = ST_IDLE;
`endif
            end
            ST_STOP: begin
                // Framing error takes precedence over a parity mismatch.
                if (bit_tick) begin
                    timer_d = '0;
                    if (!serial_sync) begin
                        ferr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (parity_bad) begin
                        perr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                timer_d   = '0;
                state_d   = ST_IDLE;
                pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + CW'(1);
            end
            default: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync_prev_q <= 1'b1;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
`ifdef PIXEL_RX_PARITY_EN
            par_acc_q   <= 1'b0;
`endif
        end else begin
            sync1_q     <= serial_in;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
`ifdef PIXEL_RX_PARITY_EN
            par_acc_q   <= par_acc_d;
`endif
        end
    end

    assign serial_sync   = sync2_q;
    assign shift_enable  = (state_q == ST_DATA) && bit_tick;
    assign load_pixel    = (state_q == ST_LOAD);
    assign image_done    = load_pixel && (pix_cnt_q == PIX_LAST);
    assign framing_error = ferr_q;
    assign parity_error  = perr_q;
    assign pixel_count   = pix_cnt_q;

endmodule

// File: tb/tb_pixel_rx_ctrl.sv
// Scoreboard bench for pixel_rx_ctrl: frames are queued with their expected outcome
// and a negedge monitor pops and compares whenever the DUT reports load or error.
module tb_pixel_rx_ctrl;

    localparam int NB  = 8;
    localparam int CPB = 4;
    localparam int PPI = 4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       serial_in;
    logic       serial_sync;
    logic       shift_enable;
    logic       load_pixel;
    logic       framing_error;
    logic       parity_error;
    logic [1:0] pixel_count;
    logic       image_done;

    pixel_rx_ctrl #(
        .NUM_BITS        (NB),
        .CLKS_PER_BIT    (CPB),
        .PIXELS_PER_IMAGE(PPI)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .serial_sync  (serial_sync),
        .shift_enable (shift_enable),
        .load_pixel   (load_pixel),
        .framing_error(framing_error),
        .parity_error (parity_error),
        .pixel_count  (pixel_count),
        .image_done   (image_done)
    );

    always #5 clk = ~clk;

    // kind: 0 = load, 1 = framing error, 2 = parity error
    typedef struct {
        int         kind;
        int         cnt;
        bit         done;
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t       exp_q[$];
    int         checks    = 0;
    int         passes    = 0;
    int         shift_cnt = 0;
    int         cyc       = 0;
    int         last_shift = 0;
    int         model_cnt = 0;
    logic [7:0] shreg     = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic driveBit(input logic b);
        serial_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic par_bit);
        exp_t e;
        logic bad_par;
`ifdef PIXEL_RX_PARITY_EN
        bad_par = (^data) ^ par_bit;
`else
        bad_par = 1'b0;
`endif
        e.data = data;
        e.par  = par_bit;
        e.cnt  = model_cnt;
        e.done = 1'b0;
        if (!stop_bit) e.kind = 1;
        else if (bad_par) e.kind = 2;
        else begin
            e.kind    = 0;
            e.done    = (model_cnt == PPI - 1);
            model_cnt = (model_cnt + 1) % PPI;
        end
        exp_q.push_back(e);
        driveBit(1'b0);
        for (int i = 0; i < NB; i++) driveBit(data[i]);
`ifdef PIXEL_RX_PARITY_EN
        driveBit(par_bit);
`endif
        driveBit(stop_bit);
        serial_in = 1'b1;
        repeat (CPB * $urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("queue_drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: models the external shift register and checks every reported frame.
    initial begin
        exp_t e;
        int   kind;
        forever begin
            @(negedge clk);
            cyc++;
            if (!n_rst) begin
                shift_cnt = 0;
            end else begin
                if (shift_enable) begin
                    if (shift_cnt > 0) checkOutput("shift_gap", cyc - last_shift, CPB);
                    last_shift = cyc;
                    shift_cnt++;
                    shreg = {serial_sync, shreg[7:1]};
                end
                if (image_done && !load_pixel) checkOutput("image_done_without_load", 1, 0);
                if (load_pixel || framing_error || parity_error) begin
                    kind = load_pixel ? 0 : (framing_error ? 1 : 2);
                    checkOutput("single_event", int'(load_pixel) + int'(framing_error) + int'(parity_error), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected_event: got kind %0d expected none", kind);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("event_kind", kind, e.kind);
                        checkOutput("shift_pulses", shift_cnt, NB);
                        checkOutput("pixel_count_at_event", pixel_count, e.cnt);
                        checkOutput("image_done", image_done, e.done);
                        if (kind == 0) checkOutput("pixel_data", shreg, e.data);
                    end
                    shift_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       stop_b;
        logic       par_b;
        n_rst     = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_serial_sync", serial_sync, 1);
        checkOutput("rst_shift_enable", shift_enable, 0);
        checkOutput("rst_load_pixel", load_pixel, 0);
        checkOutput("rst_framing_error", framing_error, 0);
        checkOutput("rst_parity_error", parity_error, 0);
        checkOutput("rst_pixel_count", pixel_count, 0);
        checkOutput("rst_image_done", image_done, 0);
        @(posedge clk);
        #2 n_rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] single frame 0xA5");
        d = 8'hA5;
        applyStimulus(d, 1'b1, ^d);
        drain();
        checkOutput("count_after_A5", pixel_count, 1);

        $display("[TB] complete the image");
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            applyStimulus(d, 1'b1, ^d);
        end
        drain();
        checkOutput("count_after_image", pixel_count, 0);

        $display("[TB] framing error frame 0x3C");
        d = 8'h3C;
        applyStimulus(d, 1'b0, ^d);
        drain();
        checkOutput("count_after_ferr", pixel_count, 0);

        $display("[TB] one-cycle glitch");
        serial_in = 1'b0;
        @(negedge clk);
        serial_in = 1'b1;
        repeat (8 * CPB) @(negedge clk);
        checkOutput("glitch_shift_pulses", shift_cnt, 0);
        checkOutput("glitch_count", pixel_count, 0);

        $display("[TB] reset mid-frame");
        d = 8'h9B;
        applyStimulus(d, 1'b1, ^d);
        drain();
        d = 8'h5A;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(d[i]);
        serial_in = d[4];
        for (int i = 0; i < 100 && shift_cnt < 4; i++) @(negedge clk);
        checkOutput("abort_reached_bit4", shift_cnt, 4);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("abort_shift_enable", shift_enable, 0);
        checkOutput("abort_load_pixel", load_pixel, 0);
        checkOutput("abort_framing_error", framing_error, 0);
        checkOutput("abort_parity_error", parity_error, 0);
        checkOutput("abort_image_done", image_done, 0);
        checkOutput("abort_pixel_count", pixel_count, 0);
        checkOutput("abort_serial_sync", serial_sync, 1);
        model_cnt = 0;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 n_rst = 1'b1;
        repeat (3) @(negedge clk);
        d = 8'hFF;
        applyStimulus(d, 1'b1, ^d);
        drain();
        checkOutput("count_after_FF", pixel_count, 1);

`ifdef PIXEL_RX_PARITY_EN
        $display("[TB] parity frames");
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h01, 1'b1, 1'b1);
        drain();
        checkOutput("count_after_parity", pixel_count, model_cnt);
`endif

        $display("[TB] random frames");
        for (int i = 0; i < 24; i++) begin
            d      = 8'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 4) != 0);
            par_b  = (^d) ^ ($urandom_range(0, 3) == 0);
            applyStimulus(d, stop_b, par_b);
        end
        drain();
        checkOutput("count_after_random", pixel_count, model_cnt);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
